// File: rtl/note_sequencer.sv
// Note sequencer: queues CPU note entries and plays each for its duration in ticks, then an optional silent gap.
// Latency: push at edge N into an idle, empty queue -> LOAD at N+1, mode valid at N+2; pushes while full are dropped and flagged.
module note_sequencer #(
    parameter int DEPTH     = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        tick,
    input  logic        stop,
    output logic [7:0]  mode,
    output logic [31:0] status
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [3:0] LVL_FULL = 4'(DEPTH);
    localparam logic [7:0] GAP_INIT = 8'(GAP_TICKS);

    logic [15:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [3:0]       r_level;
    logic             r_overflow;
    logic [1:0]       r_state;
    logic [7:0]       r_mode;
    logic [7:0]       r_remain;
    logic [7:0]       r_gap;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head;
    logic [7:0]  w_note;
    logic [7:0]  w_dur;
    logic        w_unused;

    assign w_empty  = (r_level == 4'd0);
    assign w_full   = (r_level == LVL_FULL);
    assign w_push   = wr_en && !w_full && !stop;
    assign w_pop    = (r_state == S_LOAD) && !stop;
    assign w_head   = r_mem[r_rd_ptr];
    // Codes above 13 have no tone and play as a rest; zero duration still lasts one tick.
    assign w_note   = (w_head[7:0] > 8'd13) ? 8'd0 : w_head[7:0];
    assign w_dur    = (w_head[15:8] == 8'd0) ? 8'd1 : w_head[15:8];
    assign w_unused = ^wr_data[31:16];

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= wr_data[15:0];
        end
    end

    // Full is judged on the pre-edge level, so a push to a full queue is dropped even if LOAD pops this cycle.
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 4'd1;
                2'b01:   r_level <= r_level - 4'd1;
                default: r_level <= r_level;
            endcase
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_state  <= S_IDLE;
            r_mode   <= 8'd0;
            r_remain <= 8'd0;
            r_gap    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mode <= 8'd0;
                    if (!w_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_mode   <= w_note;
                    r_remain <= w_dur;
                    r_state  <= S_PLAY;
                end
                S_PLAY: begin
                    if (tick) begin
                        if (r_remain == 8'd1) begin
                            r_mode   <= 8'd0;
                            r_remain <= 8'd0;
                            if (GAP_TICKS > 0) begin
                                r_state <= S_GAP;
                                r_gap   <= GAP_INIT;
                            end else begin
                                r_state <= w_empty ? S_IDLE : S_LOAD;
                            end
                        end else begin
                            r_remain <= r_remain - 8'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (r_gap == 8'd1) begin
                            r_gap   <= 8'd0;
                            r_state <= w_empty ? S_IDLE : S_LOAD;
                        end else begin
                            r_gap <= r_gap - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign mode   = r_mode;
    assign status = {24'd0, r_overflow, (r_state != S_IDLE), w_full, w_empty, r_level};

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: vector table and corner sequences on GAP_TICKS=1/0 instances, then random traffic against a queue model.
module tb_note_sequencer;
    localparam int DEPTH = 8;
    localparam int MGAP  = 1;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_PLAY = 2;
    localparam int P_GAP  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        tick;
    logic        stop;
    logic [7:0]  dmode1;
    logic [31:0] dstat1;
    logic [7:0]  dmode0;
    logic [31:0] dstat0;

    int total = 0;
    int bad   = 0;

    always #8 clk = ~clk;

    note_sequencer #(.DEPTH(DEPTH), .GAP_TICKS(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tick(tick), .stop(stop), .mode(dmode1), .status(dstat1)
    );

    note_sequencer #(.DEPTH(DEPTH), .GAP_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tick(tick), .stop(stop), .mode(dmode0), .status(dstat0)
    );

    typedef struct {
        bit          sel;
        bit          rst;
        bit          we;
        logic [15:0] wd;
        bit          tk;
        bit          sp;
        logic [7:0]  em;
        logic [31:0] es;
    } vec_t;

    vec_t vt[$];

    // Reference model: a plain queue of pending entries plus the current phase of playback.
    logic [15:0] mq[$];
    int          m_ph   = P_IDLE;
    int          m_left = 0;
    logic [7:0]  m_mode = 8'd0;
    bit          m_ovf  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input bit rst, input bit we, input logic [15:0] wd, input bit tk, input bit sp);
        reset   = rst;
        wr_en   = we;
        wr_data = {16'hABCD, wd};
        tick    = tk;
        stop    = sp;
        cyc();
        reset = 1'b0;
        wr_en = 1'b0;
        tick  = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic add(input bit sel, input bit rst, input bit we, input logic [15:0] wd,
                       input bit tk, input bit sp, input logic [7:0] em, input logic [31:0] es);
        vec_t v;
        v.sel = sel; v.rst = rst; v.we = we; v.wd = wd;
        v.tk = tk; v.sp = sp; v.em = em; v.es = es;
        vt.push_back(v);
    endtask

    task automatic model_step(input bit r, input bit s, input bit we, input logic [15:0] wd, input bit tk);
        bit          was_full;
        bit          was_empty;
        logic [15:0] e;
        if (r || s) begin
            mq.delete();
            m_ph   = P_IDLE;
            m_left = 0;
            m_mode = 8'd0;
            m_ovf  = 1'b0;
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        case (m_ph)
            P_IDLE: begin
                m_mode = 8'd0;
                if (!was_empty) m_ph = P_LOAD;
            end
            P_LOAD: begin
                e      = mq.pop_front();
                m_mode = (e[7:0] > 8'd13) ? 8'd0 : e[7:0];
                m_left = (e[15:8] == 8'd0) ? 1 : int'(e[15:8]);
                m_ph   = P_PLAY;
            end
            P_PLAY: begin
                if (tk) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode = 8'd0;
                        if (MGAP > 0) begin
                            m_ph   = P_GAP;
                            m_left = MGAP;
                        end else begin
                            m_ph = was_empty ? P_IDLE : P_LOAD;
                        end
                    end
                end
            end
            default: begin
                if (tk) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_ph = was_empty ? P_IDLE : P_LOAD;
                end
            end
        endcase
        if (we) begin
            if (was_full) m_ovf = 1'b1;
            else mq.push_back(wd);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [3:0] lvl;
        lvl = 4'(mq.size());
        return {24'd0, m_ovf, (m_ph != P_IDLE), (mq.size() == DEPTH), (mq.size() == 0), lvl};
    endfunction

    initial begin
        logic [7:0]  seen[$];
        logic [7:0]  prev;
        int          anomalies;
        int          saw12;
        logic [15:0] wd;
        logic [31:0] am;
        logic [31:0] as;

        reset = 1'b1; wr_en = 1'b0; wr_data = 32'd0; tick = 1'b0; stop = 1'b0;

        // Single note on GAP_TICKS=1; ticks during IDLE->LOAD and LOAD are ignored.
        add(0, 1, 0, 16'h0000, 0, 0, 8'd0,  32'h10);
        add(0, 0, 1, 16'h030A, 0, 0, 8'd0,  32'h01);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h41);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd10, 32'h50);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd10, 32'h50);
        add(0, 0, 0, 16'h0000, 0, 0, 8'd10, 32'h50);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd10, 32'h50);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h50);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h10);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h10);
        // Back-to-back notes on GAP_TICKS=0: a single LOAD cycle of silence between them.
        add(1, 1, 0, 16'h0000, 0, 0, 8'd0,  32'h10);
        add(1, 0, 1, 16'h0101, 0, 0, 8'd0,  32'h01);
        add(1, 0, 1, 16'h0105, 0, 0, 8'd0,  32'h42);
        add(1, 0, 0, 16'h0000, 0, 0, 8'd1,  32'h41);
        add(1, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h41);
        add(1, 0, 0, 16'h0000, 0, 0, 8'd5,  32'h50);
        add(1, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h10);
        add(1, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h10);
        // Out-of-range code plays as a rest; zero duration plays for one tick.
        add(0, 1, 0, 16'h0000, 0, 0, 8'd0,  32'h10);
        add(0, 0, 1, 16'h020E, 0, 0, 8'd0,  32'h01);
        add(0, 0, 1, 16'h0003, 0, 0, 8'd0,  32'h42);
        add(0, 0, 0, 16'h0000, 0, 0, 8'd0,  32'h41);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h41);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h41);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h41);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd3,  32'h50);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h50);
        add(0, 0, 0, 16'h0000, 1, 0, 8'd0,  32'h10);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rst, vt[i].we, vt[i].wd, vt[i].tk, vt[i].sp);
            am = vt[i].sel ? {24'd0, dmode0} : {24'd0, dmode1};
            as = vt[i].sel ? dstat0 : dstat1;
            chk($sformatf("vec%0d_mode", i), am, {24'd0, vt[i].em});
            chk($sformatf("vec%0d_status", i), as, vt[i].es);
        end

        // Overflow: one note playing, eight queued, the ninth push dropped.
        step(1, 0, 16'h0, 0, 0);
        step(0, 1, 16'h0101, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        chk("ovf_first_note", {24'd0, dmode1}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            wd = (k < 8) ? {8'h01, 8'(k + 2)} : 16'h010C;
            step(0, 1, wd, 0, 0);
        end
        chk("ovf_status", dstat1, 32'hE8);
        prev = 8'd1;
        saw12 = 0;
        for (int c = 0; c < 300; c++) begin
            step(0, 0, 16'h0, 1, 0);
            if (dmode1 != 8'd0 && prev == 8'd0) seen.push_back(dmode1);
            if (dmode1 == 8'd12) saw12++;
            prev = dmode1;
            if (dstat1 == 32'h90) break;
        end
        chk("ovf_drain_status", dstat1, 32'h90);
        chk("ovf_played_count", seen.size(), 32'd8);
        for (int j = 0; j < seen.size() && j < 8; j++)
            chk($sformatf("ovf_order%0d", j), {24'd0, seen[j]}, 32'(j + 2));
        chk("ovf_dropped_never_plays", saw12, 32'd0);

        // Stop mid-PLAY with four queued and a same-cycle write and tick.
        step(1, 0, 16'h0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            wd = (k == 0) ? 16'h0507 : {8'h01, 8'(k + 1)};
            step(0, 1, wd, 0, 0);
        end
        chk("stop_pre_mode", {24'd0, dmode1}, 32'd7);
        chk("stop_pre_status", dstat1, 32'h44);
        step(0, 1, 16'h0109, 1, 1);
        chk("stop_mode", {24'd0, dmode1}, 32'd0);
        chk("stop_status", dstat1, 32'h10);
        anomalies = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 0, 16'h0, 1, 0);
            if (dmode1 != 8'd0 || dstat1 != 32'h10) anomalies++;
        end
        chk("stop_quiet", anomalies, 32'd0);

        // Reset during GAP with two entries still queued.
        step(1, 0, 16'h0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 16'h0104, 0, 0);
        chk("rgap_play_mode", {24'd0, dmode1}, 32'd4);
        chk("rgap_play_status", dstat1, 32'h42);
        step(0, 0, 16'h0, 1, 0);
        chk("rgap_gap_mode", {24'd0, dmode1}, 32'd0);
        chk("rgap_gap_status", dstat1, 32'h42);
        step(1, 0, 16'h0, 1, 0);
        chk("rgap_reset_mode", {24'd0, dmode1}, 32'd0);
        chk("rgap_reset_status", dstat1, 32'h10);
        anomalies = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 0, 16'h0, 1, 0);
            if (dmode1 != 8'd0 || dstat1 != 32'h10) anomalies++;
        end
        chk("rgap_quiet", anomalies, 32'd0);

        // Random traffic against the queue model (GAP_TICKS=1 instance).
        for (int i = 0; i < 1500; i++) begin
            reset   = (i == 0) || ($urandom_range(0, 199) == 0);
            stop    = ($urandom_range(0, 49) == 0);
            wr_en   = ($urandom_range(0, 99) < 35);
            wr_data = $urandom;
            wr_data[15:8] = 8'($urandom_range(0, 3));
            wr_data[7:0]  = 8'($urandom_range(0, 15));
            tick    = ($urandom_range(0, 99) < 30);
            model_step(reset, stop, wr_en, wr_data[15:0], tick);
            cyc();
            chk($sformatf("rnd%0d_mode", i), {24'd0, dmode1}, {24'd0, m_mode});
            chk($sformatf("rnd%0d_status", i), dstat1, model_status());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
